// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, reads the combinational ROM and queues {pc, word}
// pairs in a small in-order FIFO drained by decode over a valid/ready handshake.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned AW       = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] rom_addr,
  input  logic [31:0]   rom_data,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [31:0]   inst,
  output logic [31:0]   inst_pc
);

  localparam int unsigned PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DepthCnt = (PW+1)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  logic [31:0] mem_pc   [DEPTH];
  logic [31:0] mem_word [DEPTH];

  logic pop;
  logic push;

  assign rom_addr = pc_q[AW-1:0];

  // Head outputs depend on FIFO state only; an empty FIFO presents the NOP encoding.
  always_comb begin
    inst_valid = (count_q != '0);
    inst       = 32'h0;
    inst_pc    = 32'h0;
    if (inst_valid) begin
      inst    = mem_word[rd_ptr_q];
      inst_pc = mem_pc[rd_ptr_q];
    end
  end

  assign pop  = inst_valid & inst_ready;
  assign push = ~redirect & ((count_q < DepthCnt) | pop);

  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      // A pop in this cycle has already completed; flushing discards only what remains.
      pc_d     = redirect_pc & ~32'h3;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + (PW+1)'(1);
      end else if (pop && !push) begin
        count_d = count_q - (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr_q]   <= pc_q;
      mem_word[wr_ptr_q] <= rom_data;
    end
  end

endmodule
